// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Measures the frequency of an asynchronous input by counting its
//            rising edges over a fixed gate window of GATE_CYCLES clk cycles.
//            Runs back-to-back windows while en is high and publishes one
//            result per window with a single-cycle valid strobe.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            sig_in     - signal under measurement (asynchronous to clk)
//            en         - level enable; low aborts a window or idles
//            freq_out   - rising-edge count of the last completed window
//            freq_valid - one-cycle pulse when freq_out/ovf are updated
//            ovf        - last completed window saturated the edge counter
//            busy       - a window is in progress or being latched
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             en,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
);

  // Bits needed to hold GATE_CYCLES-1.
  localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] C_GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  // CLK_HZ only documents the unit of the result; it must still be sane.
  if (GATE_CYCLES < 2 || CLK_HZ <= 0) begin : g_bad_param
    $error("freq_meter: GATE_CYCLES must be >= 2 and CLK_HZ > 0");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s1, r_s2, r_s3;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic                r_sat;

  logic                w_rise;
  logic                w_last;
  logic                w_edge_at_max;
  logic [CNT_W-1:0]    w_edge_nxt;
  logic                w_sat_nxt;
  logic                w_publish;

  // --------------------------------------------------------------------------
  // Input synchronizer plus history stage; runs in every state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise        = r_s2 & ~r_s3;
  assign w_last        = (r_gate_cnt == C_GATE_LAST);
  assign w_edge_at_max = (r_edge_cnt == C_CNT_MAX);

  // Edge count and saturation flag including the current cycle's rise; the
  // last GATE cycle's rise must make it into the published result.
  assign w_edge_nxt = (w_rise && !w_edge_at_max) ? r_edge_cnt + 1'b1 : r_edge_cnt;
  assign w_sat_nxt  = r_sat | (w_rise & w_edge_at_max);

  // Results are registered on the GATE->LATCH transition so that freq_valid
  // and the new freq_out are visible during the LATCH cycle itself. Abort
  // (en low) wins over reaching the end of the window.
  assign w_publish = (r_state == GATE) && en && w_last;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt = GATE;
        end
      end
      GATE: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = LATCH;
        end
      end
      LATCH: begin
        w_state_nxt = en ? GATE : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      freq_out   <= '0;
      ovf        <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= w_publish;
      if (w_publish) begin
        freq_out <= w_edge_nxt;
        ovf      <= w_sat_nxt;
      end

      if (r_state == GATE) begin
        r_gate_cnt <= r_gate_cnt + 1'b1;
        r_edge_cnt <= w_edge_nxt;
        r_sat      <= w_sat_nxt;
      end else begin
        // IDLE and LATCH both leave the counters cleared for the next
        // window; a rise during LATCH is therefore dropped (dead time).
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Directed self-checking bench for freq_meter with a 1000-cycle
//            gate window; a 32-bit and an 8-bit instance share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int GATE = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic        en;
  logic [31:0] freq_out;
  logic        freq_valid, ovf, busy;
  logic [7:0]  freq_out8;
  logic        freq_valid8, ovf8, busy8;

  int   n_vec = 0;
  int   n_err = 0;

  // Stimulus generator controls: mode 0 = hold level, 1 = period 50
  // (25 low then 25 high), 2 = toggle every clk. Bumping epoch restarts phase.
  int   mode  = 0;
  logic level = 1'b0;
  int   epoch = 0;
  int   gen_k = 0;
  int   gen_seen = 0;

  always #5 clk = ~clk;

  freq_meter #(.CLK_HZ(GATE), .GATE_CYCLES(GATE), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en),
    .freq_out(freq_out), .freq_valid(freq_valid), .ovf(ovf), .busy(busy)
  );

  freq_meter #(.CLK_HZ(GATE), .GATE_CYCLES(GATE), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .en(en),
    .freq_out(freq_out8), .freq_valid(freq_valid8), .ovf(ovf8), .busy(busy8)
  );

  // sig_in is applied 1 ns after each falling edge, after the main thread
  // has updated its controls on that same edge.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (epoch != gen_seen) begin
        gen_seen = epoch;
        gen_k    = 0;
      end
      case (mode)
        0:       sig_in = level;
        1:       sig_in = ((gen_k % 50) >= 25);
        default: sig_in = ((gen_k % 2) == 1);
      endcase
      gen_k++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges until freq_valid is seen high (bounded).
  task automatic wait_valid(output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    while (!found && lat < 3000) begin
      @(negedge clk);
      lat++;
      if (freq_valid) found = 1'b1;
    end
    if (!found) check_val("valid_timeout", {63'd0, freq_valid}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  seen;

    rst_n = 1'b0;
    en    = 1'b0;
    cyc(3);
    check_val("rst_freq_out", freq_out, 0);
    check_val("rst_ovf",      ovf, 0);
    check_val("rst_busy",     busy, 0);
    check_val("rst_valid",    freq_valid, 0);
    rst_n = 1'b1;
    cyc(3);

    // Periodic input, continuous windows.
    mode = 1; epoch++;
    cyc(7);
    en = 1'b1;
    wait_valid(lat);
    check_val("per_lat1",   lat, GATE + 1);
    check_val("per_freq1",  freq_out, 20);
    check_val("per_ovf1",   ovf, 0);
    check_val("per_freq8",  freq_out8, 20);
    check_val("per_valid8", freq_valid8, 1);
    wait_valid(lat);
    check_val("per_lat2",   lat, GATE + 1);
    check_val("per_freq2",  freq_out, 20);

    // Abort at GATE cycle 600.
    cyc(300);
    check_val("busy_gate", busy, 1);
    cyc(300);
    en = 1'b0;
    cyc(1);
    check_val("abort_busy", busy, 0);
    check_val("abort_freq", freq_out, 20);
    seen = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (freq_valid) seen = 1'b1;
    end
    check_val("abort_no_valid", seen, 0);
    check_val("abort_freq_held", freq_out, 20);
    en = 1'b1;
    wait_valid(lat);
    check_val("reen_lat",  lat, GATE + 1);
    check_val("reen_freq", freq_out, 20);

    // Reset mid-window at GATE cycle 400.
    cyc(400);
    rst_n = 1'b0;
    #1;
    check_val("mrst_freq",  freq_out, 0);
    check_val("mrst_ovf",   ovf, 0);
    check_val("mrst_busy",  busy, 0);
    check_val("mrst_valid", freq_valid, 0);
    mode = 0; level = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    mode = 1; epoch++;
    wait_valid(lat);
    check_val("mrst_lat",   lat, GATE + 1);
    check_val("mrst_res",   freq_out, 20);

    // Maximum rate; the first window after a mode change is mixed.
    mode = 2; epoch++;
    wait_valid(lat);
    wait_valid(lat);
    check_val("max_freq",   freq_out, 500);
    check_val("max_ovf",    ovf, 0);
    check_val("max_freq8",  freq_out8, 255);
    check_val("max_ovf8",   ovf8, 1);
    mode = 1; epoch++;
    wait_valid(lat);
    wait_valid(lat);
    check_val("post_freq8", freq_out8, 20);
    check_val("post_ovf8",  ovf8, 0);
    check_val("post_freq",  freq_out, 20);

    // Constant input: held 1 after reset gives one edge, then nothing.
    en = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    mode = 0; level = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    level = 1'b1;
    en    = 1'b1;
    wait_valid(lat);
    check_val("hi_lat",   lat, GATE + 1);
    check_val("hi_first", freq_out, 1);
    wait_valid(lat);
    check_val("hi_second", freq_out, 0);
    level = 1'b0;
    wait_valid(lat);
    check_val("lo_first", freq_out, 0);
    wait_valid(lat);
    check_val("lo_second", freq_out, 0);
    check_val("lo_ovf",    ovf, 0);

    // Window edge: rise on the last GATE cycle is counted.
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(GATE - 2);
    level = 1'b1;
    wait_valid(lat);
    check_val("edge_last_lat",  lat, 3);
    check_val("edge_last_freq", freq_out, 1);
    en = 1'b0;
    level = 1'b0;
    cyc(5);

    // One cycle later the rise lands in LATCH and is lost for both windows.
    en = 1'b1;
    cyc(GATE - 1);
    level = 1'b1;
    wait_valid(lat);
    check_val("edge_latch_lat",  lat, 2);
    check_val("edge_latch_freq", freq_out, 0);
    wait_valid(lat);
    check_val("edge_next_freq",  freq_out, 0);
    en = 1'b0;
    cyc(3);
    check_val("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_meter.md
# freq_meter

Measures the frequency of an asynchronous input signal by counting its rising edges over a fixed gate window of `clk` cycles. It is the measuring counterpart to the team's clock-divider blocks. Its typical use is checking a divided output such as a 1 kHz tick against the 50 MHz system clock. It publishes one result per window with a single-cycle valid strobe, and runs free while enabled.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency. Documentation only; the result is in Hz when `GATE_CYCLES == CLK_HZ`.
- `GATE_CYCLES`, default 50_000_000: gate window length in `clk` cycles, ≥ 2.
- `CNT_W`, default 32: width of the edge counter and result.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `sig_in`  in  1: signal under measurement, asynchronous to `clk`.
- `en`  in  1: level enable. High runs back-to-back windows; low aborts or idles.
- `freq_out`  out  CNT_W: rising-edge count of the last completed window.
- `freq_valid`  out  1: one-cycle pulse when `freq_out` is updated.
- `ovf`  out  1: the last completed window saturated the edge counter.
- `busy`  out  1: high while a window is in progress or being latched (state ≠ IDLE).

## Operation
- **Input stage:**
  - `sig_in` passes through a 2-FF synchronizer (s1, s2) and then a history register s3.
  - The rising-edge strobe is `rise = s2 & ~s3`.
  - s1–s3 reset to 0 and run regardless of state.
- **FSM states:** IDLE, GATE, LATCH.
  - **IDLE:** when `en`=1, go to GATE and clear `gate_cnt` and `edge_cnt` to 0.
  - **GATE:**
    - `gate_cnt` increments every cycle.
    - If `rise`=1, `edge_cnt` increments, saturating at 2^CNT_W−1. A `rise` arriving while `edge_cnt` is already at its maximum sets an internal `sat` flag.
    - When `gate_cnt == GATE_CYCLES-1`, that cycle's `rise` is still counted and the next state is LATCH.
    - If `en`=0 in any GATE cycle, go to IDLE with no result. `freq_out` and `ovf` keep their previous values. The abort takes priority over reaching the end of the window.
  - **LATCH (1 cycle):**
    - `freq_out <= edge_cnt`, `ovf <= sat`, `freq_valid <= 1`.
    - Clear `gate_cnt`, `edge_cnt` and `sat`.
    - Next state is GATE if `en`=1, else IDLE.
    - A `rise` during LATCH is not counted (dead time of 1 cycle per window).
- **Counter widths:** `gate_cnt` is wide enough to hold `GATE_CYCLES-1`. Comparisons are unsigned.
- **Reset** (any time, including mid-window): state IDLE; all counters 0; `freq_out`=0, `freq_valid`=0, `ovf`=0, `busy`=0.

## Timing
- A `sig_in` rising edge sampled at clock edge k appears as `rise` in cycle k+2 (s2 high, s3 low), plus up to 1 cycle of synchronizer uncertainty.
- **Window:**
  - The first GATE cycle is the cycle after `en` is sampled high in IDLE.
  - The window spans exactly `GATE_CYCLES` GATE cycles.
  - `freq_valid` is asserted during the LATCH cycle, one cycle after the last GATE cycle.
- **Continuous mode period:** `GATE_CYCLES + 1` clocks between successive `freq_valid` pulses.
- `freq_out` and `ovf` change only on the cycle `freq_valid` goes high. They are stable and held otherwise.
- `busy` goes high the cycle after `en` rises in IDLE. It goes low the cycle after an abort, or after a LATCH with `en`=0.
- **Maximum measurable rate:** a `sig_in` toggling every clock (1 edge per 2 cycles). Faster input is aliased and not supported.

## Test plan
All scenarios use `GATE_CYCLES`=1000 unless noted.

- **Periodic input, continuous:** reset, then `en`=1; `sig_in` with period 50 `clk` (high 25, low 25). Required: first `freq_valid` 1001 cycles after `en` sampled; `freq_out`=20, `ovf`=0; subsequent pulses every 1001 cycles, each with 20.
- **Constant input:** `sig_in` held 1 (then held 0), `en`=1. Required: `freq_out`=0 every window. A held-1 input started after reset counts exactly 1 edge in the first window only.
- **Maximum rate:** `sig_in` toggling every `clk`. Required: `freq_out`=500. Repeat with `CNT_W`=8: `freq_out`=255, `ovf`=1. A following window at period 50 gives `freq_out`=20, `ovf`=0.
- **Abort:** complete one window (result 20), then drop `en` at GATE cycle 600. Required: no `freq_valid`; `freq_out` stays 20; `busy`=0 the next cycle. Re-raising `en` starts a full fresh window.
- **Reset mid-window:** assert `rst_n`=0 at GATE cycle 400 after a prior result of 20. Required: immediately `freq_out`=0, `ovf`=0, `busy`=0, `freq_valid`=0. After release with `en`=1, the next result is 20 after 1001 cycles.
- **Window edge boundary:** place a single `sig_in` edge so `rise` lands on the last GATE cycle → counted (1). Move it 1 cycle later (LATCH) → not counted in either window.
